motor_ramp_ctrl: RTL and testbench

//  Sequencer that drives the PWM motor stage's period/dutyCycle/direction/motorbrake inputs.

---
 rtl/motor_ramp_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// Duty-slewing sequencer for the PWM motor stage: ramps toward commanded duty,
// reverses via ramp-down + braked dead time, and honours a level-sensitive estop.
module motor_ramp_ctrl #(
  parameter logic [7:0]  PERIOD      = 8'd200,
  parameter int unsigned RAMP_DIV    = 1000,
  parameter logic [7:0]  STEP        = 8'd1,
  parameter int unsigned DEAD_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic       cmd_dir,
  input  logic       estop,
  output logic [7:0] period,
  output logic [7:0] dutyCycle,
  output logic       direction,
  output logic       motorbrake,
  output logic       at_target
);

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DWL_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [DWL_W-1:0] DWL_LOAD = DWL_W'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REV_DOWN = 3'd3,
    ST_DWELL    = 3'd4,
    ST_ESTOP    = 3'd5
  } state_t;

  state_t              r_state;
  logic [PRE_W-1:0]    r_presc;
  logic [DUTY_W-1:0]   r_duty;
  logic [DUTY_W-1:0]   r_target;
  logic                r_dir;
  logic                r_tgt_dir;
  logic [DWL_W-1:0]    r_dwell;
  logic                r_cmd_ready;
  logic                r_brake;
  logic                r_at_target;

  state_t              w_state_nxt;
  logic [DUTY_W-1:0]   w_duty_nxt;
  logic [DUTY_W-1:0]   w_target_nxt;
  logic                w_dir_nxt;
  logic                w_tgt_dir_nxt;
  logic [DWL_W-1:0]    w_dwell_nxt;

  logic                w_tick;
  logic                w_accept;
  logic [DUTY_W-1:0]   w_cmd_duty;
  logic [DUTY_W:0]     w_up_sum;
  logic [DUTY_W:0]     w_dn_lim;
  logic [DUTY_W-1:0]   w_step_duty;
  logic [DUTY_W-1:0]   w_rev_duty;
  logic                w_rev_land;

  assign w_tick     = (r_presc == PRE_LAST);
  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_cmd_duty = (cmd_duty > PERIOD) ? PERIOD : cmd_duty;

  // 9-bit step arithmetic so neither direction can wrap or overshoot the target
  assign w_up_sum   = {1'b0, r_duty} + {1'b0, STEP};
  assign w_dn_lim   = {1'b0, r_target} + {1'b0, STEP};
  assign w_rev_duty = (r_duty > STEP) ? (r_duty - STEP) : '0;
  assign w_rev_land = (w_rev_duty == '0);

  always_comb begin
    w_step_duty = r_target;
    if (r_duty < r_target) begin
      w_step_duty = (w_up_sum > {1'b0, r_target}) ? r_target : w_up_sum[DUTY_W-1:0];
    end else if ({1'b0, r_duty} > w_dn_lim) begin
      w_step_duty = r_duty - STEP;
    end
  end

  // Next-state and datapath update; estop outranks commands, commands outrank ticks
  always_comb begin
    w_state_nxt   = r_state;
    w_duty_nxt    = r_duty;
    w_target_nxt  = r_target;
    w_dir_nxt     = r_dir;
    w_tgt_dir_nxt = r_tgt_dir;
    w_dwell_nxt   = r_dwell;

    if (estop) begin
      w_state_nxt  = ST_ESTOP;
      w_duty_nxt   = '0;
      w_target_nxt = '0;
      w_dwell_nxt  = '0;
    end else begin
      if (w_accept) begin
        w_target_nxt  = w_cmd_duty;
        w_tgt_dir_nxt = cmd_dir;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (cmd_dir != r_dir) begin
              w_dir_nxt   = cmd_dir;
              w_state_nxt = ST_RAMP;
            end else if (w_cmd_duty != '0) begin
              w_state_nxt = ST_RAMP;
            end
          end
        end

        ST_RAMP: begin
          if (w_accept) begin
            if (cmd_dir != r_dir) w_state_nxt = ST_REV_DOWN;
          end else if (r_duty == r_target) begin
            w_state_nxt = (r_target == '0) ? ST_IDLE : ST_HOLD;
          end else if (w_tick) begin
            w_duty_nxt = w_step_duty;
            if (w_step_duty == r_target) begin
              w_state_nxt = (r_target == '0) ? ST_IDLE : ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (w_accept) begin
            if (cmd_dir != r_dir) begin
              w_state_nxt = ST_REV_DOWN;
            end else if (w_cmd_duty != r_target) begin
              w_state_nxt = ST_RAMP;
            end
          end
        end

        ST_REV_DOWN: begin
          if (r_duty == '0) begin
            w_state_nxt = ST_DWELL;
            w_dwell_nxt = DWL_LOAD;
          end else if (w_tick) begin
            w_duty_nxt = w_rev_duty;
            if (w_rev_land) begin
              w_state_nxt = ST_DWELL;
              w_dwell_nxt = DWL_LOAD;
            end
          end
        end

        ST_DWELL: begin
          // Counter runs DEAD_CYCLES-1 down to 0, giving exactly DEAD_CYCLES braked cycles
          if (r_dwell == '0) begin
            w_dir_nxt   = r_tgt_dir;
            w_state_nxt = (r_target == '0) ? ST_IDLE : ST_RAMP;
          end else begin
            w_dwell_nxt = r_dwell - DWL_W'(1);
          end
        end

        ST_ESTOP: begin
          w_state_nxt = ST_IDLE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_duty      <= '0;
      r_target    <= '0;
      r_dir       <= 1'b0;
      r_tgt_dir   <= 1'b0;
      r_dwell     <= '0;
      r_cmd_ready <= 1'b1;
      r_brake     <= 1'b0;
      r_at_target <= 1'b1;
    end else begin
      r_presc     <= w_tick ? '0 : (r_presc + PRE_W'(1));
      r_state     <= w_state_nxt;
      r_duty      <= w_duty_nxt;
      r_target    <= w_target_nxt;
      r_dir       <= w_dir_nxt;
      r_tgt_dir   <= w_tgt_dir_nxt;
      r_dwell     <= w_dwell_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RAMP) ||
                     (w_state_nxt == ST_HOLD);
      r_brake     <= (w_state_nxt == ST_DWELL) || (w_state_nxt == ST_ESTOP);
      r_at_target <= (w_duty_nxt == w_target_nxt) &&
                     ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD));
    end
  end

  assign period     = PERIOD;
  assign dutyCycle  = r_duty;
  assign direction  = r_dir;
  assign motorbrake = r_brake;
  assign cmd_ready  = r_cmd_ready;
  assign at_target  = r_at_target;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl: expected duty steps are queued as commands
// are issued and matched against every observed dutyCycle change.
module tb_motor_ramp_ctrl;

  localparam int TB_PERIOD = 100;
  localparam int TB_DIV    = 4;
  localparam int TB_STEP   = 10;
  localparam int TB_DEAD   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_duty = 8'd0;
  logic       cmd_dir = 1'b0;
  logic       estop = 1'b0;
  logic [7:0] period;
  logic [7:0] dutyCycle;
  logic       direction;
  logic       motorbrake;
  logic       at_target;

  motor_ramp_ctrl #(
    .PERIOD     (8'(TB_PERIOD)),
    .RAMP_DIV   (TB_DIV),
    .STEP       (8'(TB_STEP)),
    .DEAD_CYCLES(TB_DEAD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_duty  (cmd_duty),
    .cmd_dir   (cmd_dir),
    .estop     (estop),
    .period    (period),
    .dutyCycle (dutyCycle),
    .direction (direction),
    .motorbrake(motorbrake),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] duty;
    logic       gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_chg = 0;
  int   prev_duty = 0;
  int   max_duty = 0;
  int   brake_cycles = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every duty change must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (int'(dutyCycle) != prev_duty) begin
        if (sb_q.size() == 0) begin
          check("duty_unexpected", int'(dutyCycle), prev_duty);
        end else begin
          e = sb_q.pop_front();
          check("duty", int'(dutyCycle), int'(e.duty));
          if (e.gap) check("tick_gap", cyc - last_chg, TB_DIV);
        end
        last_chg = cyc;
      end
      if (int'(dutyCycle) > max_duty) max_duty = int'(dutyCycle);
      if (motorbrake) brake_cycles++;
    end
    prev_duty = int'(dutyCycle);
  end

  task automatic push_one(input int duty, input bit gap);
    exp_t e;
    e.duty = 8'(duty);
    e.gap  = gap;
    sb_q.push_back(e);
  endtask

  // Expected slew sequence from the stepping rule; the first step's timing is free
  task automatic push_ramp(input int from, input int to);
    int d;
    bit first;
    d = from;
    first = 1'b1;
    while (d != to) begin
      if (to > d) d = (d + TB_STEP > to) ? to : d + TB_STEP;
      else        d = (d > to + TB_STEP) ? d - TB_STEP : to;
      push_one(d, !first);
      first = 1'b0;
    end
  endtask

  task automatic send(input int duty, input bit dir);
    @(negedge clk); #1;
    check("cmd_ready_before_send", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_duty  = 8'(duty);
    cmd_dir   = dir;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk); #1;
    end
    check("sb_drain", sb_q.size(), 0);
    @(negedge clk); #1;
  endtask

  task automatic wait_duty(input int v, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (int'(dutyCycle) == v) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_duty_reached", int'(hit), 1);
  endtask

  task automatic wait_brake(input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (motorbrake) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_brake_reached", int'(hit), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_duty"},   int'(dutyCycle), 0);
    check({tag, "_dir"},    int'(direction), 0);
    check({tag, "_brake"},  int'(motorbrake), 0);
    check({tag, "_period"}, int'(period), TB_PERIOD);
    check({tag, "_ready"},  int'(cmd_ready), 1);
    check({tag, "_attgt"},  int'(at_target), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt, rdy_bad, dz_bad, snap;
    bit started;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // 1: ramp from rest to 35 clockwise
    push_ramp(0, 35);
    send(35, 1'b1);
    check("t1_dir_now", int'(direction), 1);
    check("t1_attgt_ramping", int'(at_target), 0);
    wait_drain(100);
    check("t1_duty", int'(dutyCycle), 35);
    check("t1_attgt", int'(at_target), 1);
    check("t1_brake", int'(motorbrake), 0);
    check("t1_ready", int'(cmd_ready), 1);

    // 2: reversal 35/cw -> 50/ccw through ramp-down and braked dead time
    push_ramp(35, 0);
    push_ramp(0, 50);
    send(50, 1'b0);
    @(negedge clk); #1;
    check("t2_ready_low", int'(cmd_ready), 0);
    bcnt = 0; rdy_bad = 0; dz_bad = 0; started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (motorbrake) begin
        if (!started) begin
          started = 1'b1;
          check("t2_dir_during_dwell", int'(direction), 1);
        end
        bcnt++;
        if (dutyCycle != 8'd0) dz_bad++;
      end else if (started) begin
        break;
      end
      if (cmd_ready) rdy_bad++;
    end
    check("t2_dwell_len", bcnt, TB_DEAD);
    check("t2_ready_low_rev_dwell", rdy_bad, 0);
    check("t2_dwell_duty_nonzero", dz_bad, 0);
    check("t2_dir_flipped", int'(direction), 0);
    check("t2_ready_after", int'(cmd_ready), 1);
    wait_drain(100);
    check("t2_duty", int'(dutyCycle), 50);
    check("t2_attgt", int'(at_target), 1);

    // 3: oversize command is clipped to the period
    push_ramp(50, TB_PERIOD);
    send(250, 1'b0);
    wait_drain(100);
    repeat (12) @(negedge clk);
    #1;
    check("t3_duty_clip", int'(dutyCycle), TB_PERIOD);
    check("t3_attgt", int'(at_target), 1);
    check("t3_max_duty", max_duty, TB_PERIOD);

    // Back to rest in the same direction
    push_ramp(TB_PERIOD, 0);
    send(0, 1'b0);
    wait_drain(200);
    check("t3_idle_attgt", int'(at_target), 1);
    check("t3_idle_ready", int'(cmd_ready), 1);

    // 4: retarget downward mid-ramp; ramp cadence continues, no brake
    snap = brake_cycles;
    push_ramp(0, 40);
    send(80, 1'b0);
    wait_duty(40, 100);
    push_one(30, 1'b1);
    push_one(20, 1'b1);
    send(20, 1'b0);
    wait_drain(100);
    check("t4_duty", int'(dutyCycle), 20);
    check("t4_attgt", int'(at_target), 1);
    check("t4_no_brake", brake_cycles - snap, 0);

    // 5a: estop mid-ramp
    push_ramp(20, 40);
    send(90, 1'b0);
    wait_duty(40, 100);
    push_one(0, 1'b0);
    @(negedge clk); #1;
    estop = 1'b1;
    @(negedge clk); #1;
    check("t5r_duty", int'(dutyCycle), 0);
    check("t5r_brake", int'(motorbrake), 1);
    check("t5r_ready", int'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    #1;
    check("t5r_brake_held", int'(motorbrake), 1);
    estop = 1'b0;
    @(negedge clk); #1;
    check("t5r_brake_off", int'(motorbrake), 0);
    check("t5r_ready_back", int'(cmd_ready), 1);
    check("t5r_dir", int'(direction), 0);
    check("t5r_attgt", int'(at_target), 1);

    // 5b: estop mid-dwell keeps the pre-reversal direction
    push_ramp(0, 30);
    send(30, 1'b1);
    wait_drain(100);
    check("t5d_dir_cw", int'(direction), 1);
    push_ramp(30, 0);
    send(40, 1'b0);
    wait_brake(100);
    repeat (3) @(negedge clk);
    #1;
    estop = 1'b1;
    @(negedge clk); #1;
    check("t5d_duty", int'(dutyCycle), 0);
    check("t5d_brake", int'(motorbrake), 1);
    check("t5d_ready", int'(cmd_ready), 0);
    check("t5d_dir_held", int'(direction), 1);
    repeat (TB_DEAD + 2) @(negedge clk);
    #1;
    check("t5d_brake_held", int'(motorbrake), 1);
    estop = 1'b0;
    @(negedge clk); #1;
    check("t5d_brake_off", int'(motorbrake), 0);
    check("t5d_ready_back", int'(cmd_ready), 1);
    check("t5d_dir_retained", int'(direction), 1);
    check("t5d_sb_empty", sb_q.size(), 0);

    // 6: synchronous reset during dwell
    push_ramp(0, 20);
    send(20, 1'b1);
    wait_drain(100);
    push_ramp(20, 0);
    send(30, 1'b0);
    wait_brake(100);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("t6");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t6_idle_brake", int'(motorbrake), 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
